// File: rtl/ram_pkg.sv
// ram_pkg: shared types and constants for the parametrised single-port RAM.
// Sweep state encoding and the byte-lane width used by the write mask.
package ram_pkg;

    typedef enum logic {
        RAM_INIT  = 1'b0,
        RAM_READY = 1'b1
    } ram_state_t;

    localparam int RAM_BYTE_BITS = 8;

endpackage

// File: rtl/ram_init_sweep.sv
// ram_init_sweep: post-reset clear sequencer for ram_param.
// Only instantiated when RAM_PARAM_INIT_CLEAR_EN is defined. After reset
// drops it walks every address once, asking the top to write zero there,
// and raises ready on the edge that clears the last (all-ones) address.
module ram_init_sweep
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ready,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    ram_state_t            state;
    logic [ADDR_WIDTH-1:0] count;

    // Sweep state machine: clear one word per edge, then hold RAM_READY until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RAM_INIT;
            count <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                RAM_INIT: begin
                    count <= count + 1'b1;
                    if (count == '1) begin
                        state <= RAM_READY;
                        ready <= 1'b1;
                    end
                end
                RAM_READY: begin
                    ready <= 1'b1;
                end
            endcase
        end
    end

    // A clear write happens only on non-reset edges, so a reset edge never
    // touches the array contents.
    assign clr_we   = (state == RAM_INIT) && !reset;
    assign clr_addr = count;

endmodule

// File: rtl/ram_param.sv
// ram_param: parametrised single-port RAM with asynchronous read, rising-edge
// byte-masked write, synchronous active-high reset and a ready status flag.
// Optional feature macro: RAM_PARAM_INIT_CLEAR_EN -- when defined, the whole
// array is zeroed by a post-reset sweep before ready rises; when undefined,
// ready rises one edge after reset drops and contents are uninitialised.
module ram_param
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [ADDR_WIDTH-1:0]            address,
    input  logic [DATA_WIDTH-1:0]            in,
    input  logic                             is_write,
    input  logic [DATA_WIDTH/RAM_BYTE_BITS-1:0] byte_en,
    output logic [DATA_WIDTH-1:0]            out,
    output logic                             ready
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / RAM_BYTE_BITS;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

`ifdef RAM_PARAM_INIT_CLEAR_EN
    ram_init_sweep #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sweep (
        .clk      (clk),
        .reset    (reset),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );
`else
    // Without the sweep the array is usable one edge after reset drops
    always_ff @(posedge clk) begin
        if (reset) begin
            ready <= 1'b0;
        end else begin
            ready <= 1'b1;
        end
    end

    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NBYTES-1:0]     wr_mask;

    // Write-port mux: the clear sweep owns the port until ready, then the user
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = address;
        wr_data = in;
        wr_mask = byte_en;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = '0;
            wr_mask = '1;
        end else begin
            wr_en   = ready & is_write;
        end
    end

    // Storage update: only enabled byte lanes of the addressed word change
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wr_mask[b]) begin
                    mem[wr_addr][b*RAM_BYTE_BITS +: RAM_BYTE_BITS] <= wr_data[b*RAM_BYTE_BITS +: RAM_BYTE_BITS];
                end
            end
        end
    end

    // Zero-latency read, forced to zero until the array is ready
    assign out = ready ? mem[address] : '0;

endmodule

// File: tb/tb_ram_param.sv
// tb_ram_param: scoreboard bench for ram_param (ADDR_WIDTH=4, DATA_WIDTH=32).
// Adapts its reference model to whether RAM_PARAM_INIT_CLEAR_EN is defined.
module tb_ram_param;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef RAM_PARAM_INIT_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif
    // Edges after reset release before the array becomes ready
    localparam int N_RDY = CLEAR_EN ? DEPTH : 1;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic [AW-1:0] address  = '0;
    logic [DW-1:0] in       = '0;
    logic          is_write = 1'b0;
    logic [3:0]    byte_en  = '0;
    logic [DW-1:0] out;
    logic          ready;

    ram_param #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .in       (in),
        .is_write (is_write),
        .byte_en  (byte_en),
        .out      (out),
        .ready    (ready)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic          rdy;
        logic [DW-1:0] val;
        logic [DW-1:0] mask;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    event  smp_ev;
    int    n_tests = 0;
    int    n_fail  = 0;

    // Reference model: word contents, which bytes hold a defined value,
    // and the number of non-reset edges since the last reset edge.
    logic [DW-1:0] m_mem   [DEPTH];
    logic [3:0]    m_known [DEPTH];
    int            m_cnt;

    // Push the expected response for the current inputs, then let the monitor sample
    task automatic expect_now(input string nm);
        exp_t e;
        e.rdy = (m_cnt >= N_RDY);
        if (!e.rdy) begin
            e.val  = '0;
            e.mask = '1;
        end else begin
            e.val = m_mem[address];
            for (int b = 0; b < 4; b++) e.mask[8*b +: 8] = {8{m_known[address][b]}};
        end
        exp_q.push_back(e);
        name_q.push_back(nm);
        -> smp_ev;
        #2;
    endtask

    // One clock cycle of stimulus plus the model's view of the committing edge
    task automatic step(input bit rst, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit we, input logic [3:0] be, input string nm);
        bit rdy_before;
        @(negedge clk);
        reset    = rst;
        address  = a;
        in       = d;
        is_write = we;
        byte_en  = be;
        expect_now(nm);
        rdy_before = (m_cnt >= N_RDY);
        @(posedge clk);
        if (rst) begin
            m_cnt = 0;
        end else begin
            if (CLEAR_EN && m_cnt < DEPTH) begin
                m_mem[m_cnt]   = '0;
                m_known[m_cnt] = 4'hF;
            end else if (rdy_before && we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        m_mem[a][8*b +: 8] = d[8*b +: 8];
                        m_known[a][b]      = 1'b1;
                    end
                end
            end
            if (m_cnt < N_RDY) m_cnt++;
        end
    endtask

    // Change only the address between edges and check the combinational read
    task automatic probe(input logic [AW-1:0] a, input string nm);
        #1;
        address = a;
        expect_now(nm);
    endtask

    // Monitor: pop one expectation per sample request and compare
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(smp_ev);
            #1;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL monitor: sample requested with empty scoreboard");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_tests++;
                if (ready !== e.rdy) begin
                    n_fail++;
                    $display("FAIL %s ready @%0t: got %0b want %0b", nm, $time, ready, e.rdy);
                end
                n_tests++;
                if ((out & e.mask) !== (e.val & e.mask)) begin
                    n_fail++;
                    $display("FAIL %s out @%0t addr %h: got %h want %h (mask %h)",
                             nm, $time, address, out, e.val, e.mask);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = '0;
            m_known[i] = 4'h0;
        end
        m_cnt = 0;

        // Reset held for two edges; after the first one ready/out must be 0
        @(posedge clk);
        step(1'b1, 4'h0, 32'h0, 1'b0, 4'h0, "reset");

        // Release: ready stays low for the sweep; a write to 2 is dropped while busy
        for (int i = 0; i < N_RDY; i++) begin
            step(1'b0, AW'(i), $urandom, (i == 2), 4'hF, "release");
        end

        // Every word readable; zero after a clearing sweep
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, AW'(i), 32'h0, 1'b0, 4'h0, "read_all");
        end

        // Full-word write, then change in with is_write low
        step(1'b0, 4'hC, 32'hE5F84AB1, 1'b1, 4'hF, "wr_full");
        step(1'b0, 4'hC, 32'h5C8C6A01, 1'b0, 4'hF, "wr_hold");
        step(1'b0, 4'hC, 32'h5C8C6A01, 1'b0, 4'hF, "rd_full");

        // Byte mask 0101 merges into the stored word
        step(1'b0, 4'hC, 32'h5C8C6A01, 1'b1, 4'b0101, "wr_mask");
        step(1'b0, 4'hC, 32'h0, 1'b0, 4'h0, "rd_mask");

        // Enable-free write edge is a no-op
        step(1'b0, 4'hC, 32'hFFFFFFFF, 1'b1, 4'h0, "wr_noop");

        // Second location, then toggle address with no clock edge
        step(1'b0, 4'hA, 32'h5C8C6A01, 1'b1, 4'hF, "wr_a");
        step(1'b0, 4'hC, 32'h0, 1'b0, 4'h0, "dual_c");
        probe(4'hA, "dual_a");
        probe(4'hC, "dual_c2");
        probe(4'hA, "dual_a2");

        // Reset mid-sweep: edge 7 after release carries reset again
        step(1'b1, 4'h0, 32'h0, 1'b0, 4'h0, "rst2");
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'h7, 32'hDEADBEEF, (i == 3), 4'hF, "sweep_pre");
        end
        step(1'b1, 4'h7, 32'h0, 1'b0, 4'h0, "rst_mid");
        for (int i = 0; i < N_RDY; i++) begin
            step(1'b0, 4'h7, 32'h12345678, (i == 1), 4'hF, "sweep_re");
        end
        step(1'b0, 4'h7, 32'h0, 1'b0, 4'h0, "after_re");
        step(1'b0, 4'hC, 32'h0, 1'b0, 4'h0, "after_re_c");

        // Randomised mix of reads and masked writes
        for (int i = 0; i < 200; i++) begin
            step(1'b0, AW'($urandom_range(0, DEPTH-1)), $urandom,
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "random");
        end

        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
